// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side packer.
// Counter width helper sizes acc_cnt to hold 0..LANES inclusive.
package fifo_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int LANES_DEF = 4;

  function automatic int cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  localparam int CNT_W = cnt_w(LANES_DEF);

  typedef logic [LANES_DEF-1:0] keep_t;

endpackage

// File: rtl/fifo_rd_packer_pack_out_reg.sv
// Output holding register for packed words.
// Loads when free; holds data/keep stable while stalled.
module pack_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] ld_data,
  input  logic [KW-1:0] ld_keep,
  input  logic          m_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic [KW-1:0] m_keep,
  output logic          free
);

  assign free = !m_valid || m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_keep  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= ld_data;
      m_keep  <= ld_keep;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Async-FIFO read-side byte packer: pops bytes, emits LANES-wide words.
// Optional partial-word timeout flush under macro FLUSH_TIMEOUT_EN.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rempty,
  input  logic [WIDTH-1:0]       rdata,
  output logic                   rinc,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*LANES-1:0] m_data,
  output logic [LANES-1:0]       m_keep
);

  localparam int CW = cnt_w(LANES);
  localparam int DW = WIDTH * LANES;

  logic [CW-1:0]    acc_cnt;
  logic [CW:0]      pend;
  logic             inflight;
  logic             pop;
  logic             full;
  logic             free;
  logic             load;
  logic             flush;
  logic [DW-1:0]    acc;
  logic [DW-1:0]    ld_data;
  logic [LANES-1:0] ld_keep;

  // Count the byte still in flight so the accumulator never overflows.
  assign pend = {1'b0, acc_cnt} + {{CW{1'b0}}, inflight};
  assign pop  = !rempty && (pend < (CW+1)'(LANES));
  assign rinc = pop && !rst;
  assign full = acc_cnt == CW'(LANES);
  assign load = (full && free) || flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt  <= '0;
      inflight <= 1'b0;
      acc      <= '0;
    end else begin
      inflight <= pop;
      if (load) begin
        acc_cnt <= '0;
      end else if (inflight) begin
        acc_cnt <= acc_cnt + CW'(1);
        for (int i = 0; i < LANES; i++) begin
          if (acc_cnt == CW'(i)) begin
            acc[i*WIDTH +: WIDTH] <= rdata;
          end
        end
      end
    end
  end

`ifdef FLUSH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle;
  logic          partial;

  assign partial = (acc_cnt != '0) && !full;
  assign flush   = partial && !inflight && free
                && (idle == TW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle <= '0;
    end else if (inflight || flush || !partial) begin
      idle <= '0;
    end else if (idle != TW'(TIMEOUT)) begin
      idle <= idle + TW'(1);
    end
  end

  // Unfilled lanes go out as zero with their keep bit clear.
  always_comb begin
    ld_keep = '0;
    ld_data = '0;
    for (int i = 0; i < LANES; i++) begin
      ld_keep[i] = CW'(i) < acc_cnt;
      if (ld_keep[i]) begin
        ld_data[i*WIDTH +: WIDTH] = acc[i*WIDTH +: WIDTH];
      end
    end
  end
`else
  assign flush   = 1'b0;
  assign ld_keep = '1;
  assign ld_data = acc;
`endif

  pack_out_reg #(
    .DW(DW),
    .KW(LANES)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .ld_data(ld_data),
    .ld_keep(ld_keep),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_keep (m_keep),
    .free   (free)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer with a behavioural FIFO model.
// Expected words come from grouping the written byte stream in order.
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  localparam int W = WIDTH_DEF;
  localparam int L = LANES_DEF;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rempty;
  logic [W-1:0]   rdata = '0;
  logic           rinc;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [W*L-1:0] m_data;
  keep_t          m_keep;

  int tests = 0;
  int fails = 0;
  int pops = 0;
  int underflow = 0;

  fifo_rd_packer #(
    .WIDTH  (W),
    .LANES  (L),
    .TIMEOUT(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rempty (rempty),
    .rdata  (rdata),
    .rinc   (rinc),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_keep (m_keep)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the edge after the pop request.
  logic [7:0] mem [4096];
  int wptr = 0;
  int rptr = 0;
  assign rempty = (rptr == wptr);

  always @(posedge clk or posedge rst) begin
    if (rst) rptr <= wptr;
    else if (rinc) begin
      rdata <= mem[rptr % 4096];
      rptr  <= rptr + 1;
    end
  end

  always @(posedge clk) if (!rst && rinc) pops++;

  // Reference: bytes grouped LANES at a time, first byte in lane 0.
  logic [7:0]     mbytes [$];
  logic [W*L-1:0] exp_d [$];
  keep_t          exp_k [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic put(input logic [7:0] b);
    logic [W*L-1:0] w;
    mem[wptr % 4096] = b;
    wptr++;
    mbytes.push_back(b);
    if (mbytes.size() == L) begin
      w = '0;
      for (int i = 0; i < L; i++) w[i*W +: W] = mbytes[i];
      exp_d.push_back(w);
      exp_k.push_back('1);
      mbytes.delete();
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((exp_d.size() != 0 || m_valid) && n < lim) begin
      cycle();
      n++;
    end
    chk("drain_left", 64'(exp_d.size()), 64'd0);
  endtask

  // Monitor: compare accepted words and stall stability.
  logic           held = 1'b0;
  logic [W*L-1:0] held_d;
  keep_t          held_k;

  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (held) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(held_d));
        chk("stall_keep", 64'(m_keep), 64'(held_k));
      end
      held   = m_valid && !m_ready;
      held_d = m_data;
      held_k = m_keep;
      if (rinc && rempty) underflow++;
      if (m_valid && m_ready) begin
        if (exp_d.size() == 0) begin
          chk("unexpected_word", 64'(m_data), 64'd0);
          if (m_data == '0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_word: got word with empty queue");
          end
        end else begin
          chk("word_data", 64'(m_data), 64'(exp_d.pop_front()));
          chk("word_keep", 64'(m_keep), 64'(exp_k.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  localparam bit GAPS =
`ifdef FLUSH_TIMEOUT_EN
    1'b0;
`else
    1'b1;
`endif

  initial begin
    int p0;
    logic [W*L-1:0] w;
    keep_t k;

    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    chk("rst_keep", 64'(m_keep), 64'd0);
    chk("rst_rinc", 64'(rinc), 64'd0);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Basic pack
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) put(8'(i));
    drain(100);

    // Backpressure: 12 bytes, output stalled
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 12; i++) put(8'(i));
    repeat (30) cycle();
    chk("bp_pops", 64'(pops - p0), 64'd8);
    chk("bp_rinc", 64'(rinc), 64'd0);
    chk("bp_valid", 64'(m_valid), 64'd1);
    chk("bp_data", 64'(m_data), 64'h04030201);
    m_ready = 1'b1;
    drain(100);

    // Starvation mid-word
    put(8'hAA);
    put(8'hBB);
    put(8'hCC);
`ifdef FLUSH_TIMEOUT_EN
    w = '0;
    k = '0;
    for (int i = 0; i < mbytes.size(); i++) begin
      w[i*W +: W] = mbytes[i];
      k[i] = 1'b1;
    end
    exp_d.push_back(w);
    exp_k.push_back(k);
    mbytes.delete();
    repeat (50) cycle();
    chk("starve_left", 64'(exp_d.size()), 64'd0);
`else
    w = '0;
    k = '0;
    repeat (50) cycle();
    chk("starve_valid", 64'(m_valid), 64'(k));
`endif
    put(8'hDD);
    for (int i = 0; i < 3; i++) put(8'($urandom));
    drain(100);

    // Ready toggling each cycle, 64 bytes
    for (int i = 0; i < 64; i++) begin
      put(8'($urandom));
      m_ready = ~m_ready;
      cycle();
    end
    m_ready = 1'b1;
    drain(400);

    // Reset mid-operation with a word held and two bytes packed
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) put(8'h21 + 8'(i));
    repeat (15) cycle();
    chk("pre_rst_valid", 64'(m_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_data", 64'(m_data), 64'd0);
    chk("mid_rst_keep", 64'(m_keep), 64'd0);
    chk("mid_rst_rinc", 64'(rinc), 64'd0);
    exp_d.delete();
    exp_k.delete();
    mbytes.delete();
    cycle();
    cycle();
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) put(8'h31 + 8'(i));
    drain(100);

    // Random stress with stalls and empty gaps
    for (int i = 0; i < 400; i++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (!GAPS || $urandom_range(0, 2) != 0) put(8'($urandom));
      cycle();
    end
    while (mbytes.size() != 0) put(8'($urandom));
    m_ready = 1'b1;
    drain(2000);

    chk("underflow", 64'(underflow), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
